// File: rtl/bcd_to_bin_if.sv
// Handshake bundle between a packed-BCD producer and the bcd_to_bin converter.
// The master drives operand and start; the slave returns result and status.
interface bcd_to_bin_if #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned BIN_WIDTH = 16
);
    logic [4*DIGITS-1:0] bcd_in;
    logic                start;
    logic [BIN_WIDTH-1:0] bin_out;
    logic                done;
    logic                busy;
    logic                error;

    modport master (
        output bcd_in,
        output start,
        input  bin_out,
        input  done,
        input  busy,
        input  error
    );

    modport slave (
        input  bcd_in,
        input  start,
        output bin_out,
        output done,
        output busy,
        output error
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// shift {bcd,bin} right once per cycle, then subtract 3 from every digit >= 8.
module bcd_to_bin #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned BIN_WIDTH = 16
) (
    input logic        clk,
    input logic        reset,
    bcd_to_bin_if.slave bus
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    // True when BIN_WIDTH bits can hold the largest DIGITS-digit decimal value.
    function automatic bit width_ok();
        longint unsigned max_bcd;
        max_bcd = 64'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            max_bcd = max_bcd * 64'd10;
        end
        max_bcd = max_bcd - 64'd1;
        if (BIN_WIDTH >= 64) begin
            return 1'b1;
        end
        return (64'd1 << BIN_WIDTH) > max_bcd;
    endfunction

    localparam bit WidthOk = width_ok();

    typedef enum logic [0:0] {StIdle, StConvert} state_e;

    state_e               state_q, state_d;
    logic [BcdW-1:0]      sr_bcd_q, sr_bcd_d;
    logic [BIN_WIDTH-1:0] sr_bin_q, sr_bin_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [BIN_WIDTH-1:0] bin_out_q, bin_out_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;

    logic [BcdW-1:0]      bcd_sh;
    logic [BcdW-1:0]      bcd_adj;
    logic [BIN_WIDTH-1:0] bin_sh;
    logic                 bcd_bad;

    always_comb begin
        {bcd_sh, bin_sh} = {sr_bcd_q, sr_bin_q} >> 1;
        bcd_adj = bcd_sh;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd8) begin
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bcd_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_bcd_d  = sr_bcd_q;
        sr_bin_d  = sr_bin_q;
        count_d   = count_q;
        bin_out_d = bin_out_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        error_d   = error_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bcd_bad) begin
                        // Rejected operand: report immediately, never enter CONVERT.
                        done_d    = 1'b1;
                        error_d   = 1'b1;
                        bin_out_d = '0;
                    end else begin
                        sr_bcd_d = bus.bcd_in;
                        sr_bin_d = '0;
                        count_d  = '0;
                        busy_d   = 1'b1;
                        state_d  = StConvert;
                    end
                end
            end
            StConvert: begin
                sr_bcd_d = bcd_adj;
                sr_bin_d = bin_sh;
                count_d  = count_q + CntW'(1);
                if (count_q == CntW'(BIN_WIDTH - 1)) begin
                    bin_out_d = bin_sh;
                    done_d    = 1'b1;
                    error_d   = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sr_bcd_q  <= '0;
            sr_bin_q  <= '0;
            count_q   <= '0;
            bin_out_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_bcd_q  <= sr_bcd_d;
            sr_bin_q  <= sr_bin_d;
            count_q   <= count_d;
            bin_out_q <= bin_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        assert (WidthOk)
        else $error("bcd_to_bin: BIN_WIDTH too small for DIGITS decimal digits");
    end

    assign bus.bin_out = bin_out_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.error   = error_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: decimal-arithmetic reference model checked
// every cycle, plus directed transactions with hand-computed results.
module tb_bcd_to_bin;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned BIN_WIDTH = 16;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) bus ();

    bcd_to_bin #(
        .DIGITS   (DIGITS),
        .BIN_WIDTH(BIN_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Decimal meaning of a packed BCD word; bad if any nibble is not a decimal digit.
    task automatic dec_val(input logic [15:0] bcd, output int v, output bit bad);
        logic [3:0] d;
        int scale;
        v     = 0;
        bad   = 1'b0;
        scale = 1;
        for (int i = 0; i < 4; i++) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            v     = v + int'(d) * scale;
            scale = scale * 10;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: what the outputs must be just after each edge.
    bit          m_valid;
    int          m_pending;
    int          m_target;
    logic [15:0] m_bin;
    logic        m_err;
    logic        m_done;
    logic        m_busy;

    initial begin
        m_valid   = 1'b0;
        m_pending = 0;
        m_target  = 0;
        m_bin     = '0;
        m_err     = 1'b0;
        m_done    = 1'b0;
        m_busy    = 1'b0;
    end

    always @(posedge clk) begin
        int  v;
        bit  bad;
        m_done = 1'b0;
        dec_val(bus.bcd_in, v, bad);
        if (reset) begin
            m_valid   = 1'b1;
            m_pending = 0;
            m_bin     = '0;
            m_err     = 1'b0;
            m_busy    = 1'b0;
        end else if (m_pending > 0) begin
            m_pending--;
            if (m_pending == 0) begin
                m_done = 1'b1;
                m_busy = 1'b0;
                m_err  = 1'b0;
                m_bin  = 16'(m_target);
            end
        end else if (bus.start) begin
            if (bad) begin
                m_done = 1'b1;
                m_err  = 1'b1;
                m_bin  = '0;
            end else begin
                m_pending = BIN_WIDTH;
                m_busy    = 1'b1;
                m_target  = v;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_done", 32'(bus.done), 32'(m_done));
            check("cmp_busy", 32'(bus.busy), 32'(m_busy));
            check("cmp_error", 32'(bus.error), 32'(m_err));
            check("cmp_bin_out", 32'(bus.bin_out), 32'(m_bin));
        end
    end

    // One transaction; exp_cycles counts negedges from the start edge up to done.
    task automatic run(input string name, input logic [15:0] bcd, input logic [15:0] exp_bin,
                       input logic exp_err, input int exp_cycles, input int repulse_at);
        int cycles;
        int busy_seen;
        int extra_done;
        bit seen;
        logic [15:0] got_bin;
        logic        got_err;
        cycles     = 0;
        busy_seen  = 0;
        extra_done = 0;
        seen       = 1'b0;
        got_bin    = '0;
        got_err    = 1'b0;
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_seen++;
            if (cycles == 1) bus.start = 1'b0;
            if (repulse_at != 0 && cycles == repulse_at) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h0001;
            end
            if (repulse_at != 0 && cycles == repulse_at + 1) bus.start = 1'b0;
            if (bus.done) begin
                seen    = 1'b1;
                got_bin = bus.bin_out;
                got_err = bus.error;
            end
        end
        bus.start = 1'b0;
        check($sformatf("%s_timeout", name), 32'(seen), 32'd1);
        check($sformatf("%s_latency", name), 32'(cycles), 32'(exp_cycles));
        check($sformatf("%s_bin", name), 32'(got_bin), 32'(exp_bin));
        check($sformatf("%s_err", name), 32'(got_err), 32'(exp_err));
        check($sformatf("%s_busy_cycles", name), 32'(busy_seen), 32'(exp_cycles - 1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check($sformatf("%s_extra_done", name), 32'(extra_done), 32'd0);
        check($sformatf("%s_bin_held", name), 32'(bus.bin_out), 32'(exp_bin));
    endtask

    initial begin
        int vals[$];
        int idx;
        int since;
        int dones;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;

        repeat (3) @(negedge clk);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_error", 32'(bus.error), 32'd0);
        check("reset_bin", 32'(bus.bin_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run("c1234", 16'h1234, 16'h04D2, 1'b0, 17, 0);
        run("c9999", 16'h9999, 16'h270F, 1'b0, 17, 0);
        run("c0000", 16'h0000, 16'h0000, 1'b0, 17, 0);
        run("bad12A4", 16'h12A4, 16'h0000, 1'b1, 1, 0);
        run("c0010", 16'h0010, 16'h000A, 1'b0, 17, 0);
        run("repulse", 16'h0042, 16'h002A, 1'b0, 17, 5);

        // Reset lands mid-conversion: result abandoned, no done afterwards.
        bus.bcd_in = 16'h1234;
        bus.start  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_error", 32'(bus.error), 32'd0);
        check("midreset_bin", 32'(bus.bin_out), 32'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midreset_no_done", 32'(dones), 32'd0);
        run("after_reset", 16'h0042, 16'h002A, 1'b0, 17, 0);

        // Round trip, back-to-back with start raised on each done cycle.
        for (int v = 0; v < 10000; v += 7) vals.push_back(v);
        vals.push_back(9998);
        vals.push_back(9999);
        idx        = 0;
        since      = 0;
        bus.bcd_in = to_bcd(vals[0]);
        bus.start  = 1'b1;
        while (idx < vals.size()) begin
            @(negedge clk);
            since++;
            if (since == 1) bus.start = 1'b0;
            if (bus.done) begin
                check("rt_bin", 32'(bus.bin_out), 32'(vals[idx]));
                check("rt_err", 32'(bus.error), 32'd0);
                check("rt_period", 32'(since), 32'd17);
                idx++;
                if (idx < vals.size()) begin
                    bus.bcd_in = to_bcd(vals[idx]);
                    bus.start  = 1'b1;
                end
                since = 0;
            end else if (since > 40) begin
                check("rt_timeout", 32'(since), 32'd17);
                break;
            end
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
